// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the exec_sequencer execution unit:
//   opcode_t  - 8-bit instruction opcodes (matrix, integer, STOP)
//   state_t   - sequencer FSM states
//   ALU_OFF_* - register offsets inside a matrix-ALU sub-block
//   is_matrix_op / is_int_op - opcode class helpers
// No ports (package).
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [7:0] {
        OP_MMUL       = 8'h00,
        OP_MADD       = 8'h01,
        OP_MSUB       = 8'h02,
        OP_MTRANSPOSE = 8'h03,
        OP_MSCALE     = 8'h04,
        OP_MSCALEIMM  = 8'h05,
        OP_IADD       = 8'h10,
        OP_ISUB       = 8'h11,
        OP_IMUL       = 8'h12,
        OP_STOP       = 8'hFF
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RD_SRC1,
        S_RD_SRC2,
        S_ALU_WR1,
        S_ALU_WR2,
        S_ALU_GO,
        S_ALU_WAIT,
        S_ALU_RD,
        S_INT_EXEC,
        S_WR_DEST,
        S_RETIRE,
        S_HALT
    } state_t;

    // Register offsets within one matrix-ALU sub-block
    localparam logic [3:0] ALU_OFF_SRC1 = 4'd0;
    localparam logic [3:0] ALU_OFF_SRC2 = 4'd1;
    localparam logic [3:0] ALU_OFF_RES  = 4'd2;
    localparam logic [3:0] ALU_OFF_GO   = 4'd3;

    function automatic logic is_matrix_op(input logic [7:0] op);
        return (op <= OP_MSCALEIMM);
    endfunction

    function automatic logic is_int_op(input logic [7:0] op);
        return (op >= OP_IADD) && (op <= OP_IMUL);
    endfunction

endpackage

// File: rtl/exec_int_alu.sv
// -----------------------------------------------------------------------------
// exec_int_alu
// Combinational integer ALU for the sequencer's internal integer ops.
// Ports:
//   op [7:0]        in  - opcode (OP_IADD / OP_ISUB / OP_IMUL; others give 0)
//   a  [DATA_W-1:0] in  - first operand (src1)
//   b  [DATA_W-1:0] in  - second operand (src2)
//   y  [DATA_W-1:0] out - result
// ADD/SUB wrap modulo 2^DATA_W; MUL multiplies the low halves into a full
// DATA_W-wide product, so it can never overflow.
// -----------------------------------------------------------------------------
module exec_int_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int HALF_W = DATA_W / 2;

    logic [DATA_W-1:0] prod;

    assign prod = DATA_W'(a[HALF_W-1:0]) * DATA_W'(b[HALF_W-1:0]);

    always_comb begin
        y = '0;
        case (op)
            OP_IADD: y = a + b;
            OP_ISUB: y = a - b;
            OP_IMUL: y = prod;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Fetch/decode/execute engine. Instructions are 32-bit op_dest_src1_src2.
// Matrix ops are dispatched to the matrix ALU via memory-mapped writes,
// integer ops run in exec_int_alu. All bus traffic shares one address bus.
// Ports:
//   Clk            in  - clock, rising edge
//   Reset          in  - asynchronous, active-high reset
//   Run            in  - allows fetch of a new instruction
//   InstructDataIn in  - instruction memory read data ([31:0] used)
//   MemDataIn      in  - main memory read data
//   MatrixDataIn   in  - matrix ALU read data
//   ExeDataOut     out - bus write data (0 whenever nWrite=1)
//   Address        out - bus address
//   nRead          out - active-low read strobe
//   nWrite         out - active-low write strobe
//   PcOut          out - current program counter
//   Halted         out - sticky, STOP or illegal opcode
//   Error          out - sticky, illegal opcode
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int                DATA_W     = 256,
    parameter int                ADDR_W     = 16,
    parameter int                PC_W       = 8,
    parameter logic [ADDR_W-1:0] INSTR_BASE = 16'h8000,
    parameter logic [ADDR_W-1:0] MEM_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0] MALU_BASE  = 16'h2000,
    parameter int                RD_LAT     = 2,
    parameter int                ALU_LAT    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] InstructDataIn,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MatrixDataIn,
    output logic [DATA_W-1:0] ExeDataOut,
    output logic [ADDR_W-1:0] Address,
    output logic              nRead,
    output logic              nWrite,
    output logic [PC_W-1:0]   PcOut,
    output logic              Halted,
    output logic              Error
);

    localparam int CNT_MAX   = (RD_LAT > ALU_LAT) ? RD_LAT : ALU_LAT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1) + 1;
    localparam int WAIT_LAST = (ALU_LAT > 0) ? ALU_LAT - 1 : 0;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [31:0]       instr_reg;
    logic [DATA_W-1:0] src1_reg;
    logic [DATA_W-1:0] src2_reg;
    logic [DATA_W-1:0] res_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              nread_reg;
    logic              nwrite_reg;
    logic              halted_reg;
    logic              error_reg;

    // Instruction fields
    logic [7:0] op;
    logic [7:0] dest_f;
    logic [7:0] src1_f;
    logic [7:0] src2_f;

    assign op     = instr_reg[31:24];
    assign dest_f = instr_reg[23:16];
    assign src1_f = instr_reg[15:8];
    assign src2_f = instr_reg[7:0];

    // Only the low instruction word is meaningful
    logic unused_instr_hi;
    assign unused_instr_hi = ^InstructDataIn[DATA_W-1:32];

    logic is_mat;
    logic is_int;
    logic no_src2_rd;
    logic skip_wr2;
    logic [ADDR_W-1:0] malu_sub;

    assign is_mat     = is_matrix_op(op);
    assign is_int     = is_int_op(op);
    // TRANSPOSE is unary; SCALEIMM takes src2 as an immediate
    assign no_src2_rd = (op == OP_MTRANSPOSE) || (op == OP_MSCALEIMM);
    assign skip_wr2   = (op == OP_MTRANSPOSE);
    assign malu_sub   = MALU_BASE | (ADDR_W'(op[3:0]) << 4);

    logic [DATA_W-1:0] int_y;

    exec_int_alu #(
        .DATA_W (DATA_W)
    ) u_int_alu (
        .op (op),
        .a  (src1_reg),
        .b  (src2_reg),
        .y  (int_y)
    );

    // Per-state bus target and the state to move to once the bus
    // transaction of the current state completes.
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] wr_data;
    state_t            done_state;

    always_comb begin
        bus_addr   = '0;
        wr_data    = '0;
        done_state = S_IDLE;
        case (state_reg)
            S_FETCH: begin
                bus_addr   = INSTR_BASE + ADDR_W'(pc_reg);
                done_state = S_DECODE;
            end
            S_RD_SRC1: begin
                bus_addr   = MEM_BASE + ADDR_W'(src1_f);
                done_state = no_src2_rd ? S_ALU_WR1 : S_RD_SRC2;
            end
            S_RD_SRC2: begin
                bus_addr   = MEM_BASE + ADDR_W'(src2_f);
                done_state = is_int ? S_INT_EXEC : S_ALU_WR1;
            end
            S_ALU_WR1: begin
                bus_addr   = malu_sub | ADDR_W'(ALU_OFF_SRC1);
                wr_data    = src1_reg;
                done_state = skip_wr2 ? S_ALU_GO : S_ALU_WR2;
            end
            S_ALU_WR2: begin
                bus_addr   = malu_sub | ADDR_W'(ALU_OFF_SRC2);
                wr_data    = (op == OP_MSCALEIMM) ? DATA_W'(src2_f) : src2_reg;
                done_state = S_ALU_GO;
            end
            S_ALU_GO: begin
                bus_addr   = malu_sub | ADDR_W'(ALU_OFF_GO);
                done_state = (ALU_LAT == 0) ? S_ALU_RD : S_ALU_WAIT;
            end
            S_ALU_RD: begin
                bus_addr   = malu_sub | ADDR_W'(ALU_OFF_RES);
                done_state = S_WR_DEST;
            end
            S_WR_DEST: begin
                bus_addr   = MEM_BASE + ADDR_W'(dest_f);
                wr_data    = res_reg;
                done_state = S_RETIRE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            pc_reg     <= '0;
            instr_reg  <= '0;
            src1_reg   <= '0;
            src2_reg   <= '0;
            res_reg    <= '0;
            dout_reg   <= '0;
            addr_reg   <= '0;
            nread_reg  <= 1'b1;
            nwrite_reg <= 1'b1;
            halted_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (Run) begin
                        state_reg <= S_FETCH;
                    end
                end

                // Read: cnt 0 asserts nRead, data is sampled on the edge where
                // cnt reaches RD_LAT. The next state always starts at cnt 0
                // with nRead high, giving the mandatory idle cycle.
                S_FETCH, S_RD_SRC1, S_RD_SRC2, S_ALU_RD: begin
                    if (cnt_reg == '0) begin
                        addr_reg  <= bus_addr;
                        nread_reg <= 1'b0;
                        cnt_reg   <= CNT_W'(1);
                    end else if (cnt_reg == CNT_W'(RD_LAT)) begin
                        nread_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= done_state;
                        case (state_reg)
                            S_FETCH:   instr_reg <= InstructDataIn[31:0];
                            S_RD_SRC1: src1_reg  <= MemDataIn;
                            S_RD_SRC2: src2_reg  <= MemDataIn;
                            default:   res_reg   <= MatrixDataIn;
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                // Write: one cycle with nWrite low, then release and clear data
                S_ALU_WR1, S_ALU_WR2, S_ALU_GO, S_WR_DEST: begin
                    if (cnt_reg == '0) begin
                        addr_reg   <= bus_addr;
                        dout_reg   <= wr_data;
                        nwrite_reg <= 1'b0;
                        cnt_reg    <= CNT_W'(1);
                    end else begin
                        nwrite_reg <= 1'b1;
                        dout_reg   <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= done_state;
                    end
                end

                S_DECODE: begin
                    cnt_reg <= '0;
                    if (is_mat || is_int) begin
                        state_reg <= S_RD_SRC1;
                    end else if (op == OP_STOP) begin
                        halted_reg <= 1'b1;
                        state_reg  <= S_HALT;
                    end else begin
                        error_reg  <= 1'b1;
                        halted_reg <= 1'b1;
                        state_reg  <= S_HALT;
                    end
                end

                S_ALU_WAIT: begin
                    if (cnt_reg == CNT_W'(WAIT_LAST)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_ALU_RD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_INT_EXEC: begin
                    res_reg   <= int_y;
                    state_reg <= S_WR_DEST;
                end

                S_RETIRE: begin
                    pc_reg    <= pc_reg + PC_W'(1);
                    cnt_reg   <= '0;
                    state_reg <= Run ? S_FETCH : S_IDLE;
                end

                S_HALT: ;

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ExeDataOut = dout_reg;
    assign Address    = addr_reg;
    assign nRead      = nread_reg;
    assign nWrite     = nwrite_reg;
    assign PcOut      = pc_reg;
    assign Halted     = halted_reg;
    assign Error      = error_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Scoreboard bench: a reference model expands each program into the ordered
// list of bus reads/writes it must produce; a monitor thread pops that list
// as the DUT strobes the bus. Memories and the matrix ALU are bench models.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 16;
    localparam int PC_W    = 8;
    localparam int RD_LAT  = 2;
    localparam int ALU_LAT = 1;
    localparam logic [DATA_W-1:0] GARBAGE = {8{32'hDEADBEEF}};

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Run = 1'b0;
    logic [DATA_W-1:0] InstructDataIn;
    logic [DATA_W-1:0] MemDataIn;
    logic [DATA_W-1:0] MatrixDataIn;
    logic [DATA_W-1:0] ExeDataOut;
    logic [ADDR_W-1:0] Address;
    logic              nRead;
    logic              nWrite;
    logic [PC_W-1:0]   PcOut;
    logic              Halted;
    logic              Error;

    exec_sequencer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .PC_W    (PC_W),
        .RD_LAT  (RD_LAT),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run            (Run),
        .InstructDataIn (InstructDataIn),
        .MemDataIn      (MemDataIn),
        .MatrixDataIn   (MatrixDataIn),
        .ExeDataOut     (ExeDataOut),
        .Address        (Address),
        .nRead          (nRead),
        .nWrite         (nWrite),
        .PcOut          (PcOut),
        .Halted         (Halted),
        .Error          (Error)
    );

    always #5 Clk = ~Clk;

    // ---------------- bench-side memories and matrix ALU ----------------
    logic [31:0]       imem [256];
    logic [DATA_W-1:0] mem  [256];
    logic [DATA_W-1:0] malu_s1;
    logic [DATA_W-1:0] malu_s2;
    logic [DATA_W-1:0] malu_res;
    int                low_cnt;

    // Data is valid only on the RD_LAT-th edge after nRead falls
    wire data_ok = !nRead && (low_cnt == RD_LAT);

    assign InstructDataIn = (data_ok && Address[15:8] == 8'h80) ? {224'b0, imem[Address[7:0]]} : GARBAGE;
    assign MemDataIn      = (data_ok && Address[15:8] == 8'h00) ? mem[Address[7:0]] : GARBAGE;
    assign MatrixDataIn   = (data_ok && Address[15:8] == 8'h20 && Address[3:0] == 4'h2) ? malu_res : GARBAGE;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [15:0] sub,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return a + (b << 1) + b + {240'b0, sub};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit                wr;
        logic [15:0]       addr;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t expq[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic push(input bit wr, input logic [15:0] addr, input logic [DATA_W-1:0] data);
        ev_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_event(input bit wr, input logic [15:0] addr, input logic [DATA_W-1:0] data);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bus_%s addr=%h data=%h", wr ? "write" : "read", addr, data);
        end else begin
            e = expq.pop_front();
            if (e.wr != wr || e.addr !== addr || (wr && e.data !== data)) begin
                failures++;
                $display("FAIL bus_event got %s addr=%h data=%h, expected %s addr=%h data=%h",
                         wr ? "WR" : "RD", addr, data, e.wr ? "WR" : "RD", e.addr, e.data);
            end else begin
                $display("tb: %s addr=%h data=%h ok", wr ? "WR" : "RD", addr, wr ? data : '0);
            end
        end
    endtask

    // Reference model: expands the program in imem (starting at PC 0) into
    // the bus events it must generate, using a private copy of main memory.
    task automatic build_expect(output logic [7:0] stop_pc, output bit stop_err);
        logic [DATA_W-1:0] m [256];
        logic [DATA_W-1:0] a, b, r;
        logic [7:0]        pc, op, d, s1, s2;
        logic [15:0]       sub;
        bit                done;
        m = mem; pc = 8'd0; stop_pc = 8'd0; stop_err = 1'b0; done = 1'b0;
        expq.delete();
        for (int k = 0; k < 256 && !done; k++) begin
            push(1'b0, 16'h8000 + {8'h00, pc}, '0);
            {op, d, s1, s2} = imem[pc];
            if (op <= 8'h05) begin
                sub = 16'h2000 | {4'h0, op, 4'h0};
                push(1'b0, {8'h00, s1}, '0);
                a = m[s1];
                b = '0;
                if (op == 8'h05) begin
                    b = {248'b0, s2};
                end else if (op != 8'h03) begin
                    push(1'b0, {8'h00, s2}, '0);
                    b = m[s2];
                end
                push(1'b1, sub, a);
                if (op != 8'h03) push(1'b1, sub | 16'h0001, b);
                push(1'b1, sub | 16'h0003, '0);
                push(1'b0, sub | 16'h0002, '0);
                r = alu_fn(sub, a, b);
                push(1'b1, {8'h00, d}, r);
                m[d] = r;
            end else if (op >= 8'h10 && op <= 8'h12) begin
                push(1'b0, {8'h00, s1}, '0);
                push(1'b0, {8'h00, s2}, '0);
                a = m[s1];
                b = m[s2];
                if (op == 8'h10)      r = a + b;
                else if (op == 8'h11) r = a - b;
                else                  r = {128'b0, a[127:0]} * {128'b0, b[127:0]};
                push(1'b1, {8'h00, d}, r);
                m[d] = r;
            end else begin
                stop_pc  = pc;
                stop_err = (op != 8'hFF);
                done     = 1'b1;
            end
            pc = pc + 8'd1;
        end
    endtask

    // Monitor thread: pops the scoreboard and plays the memory/ALU devices
    task automatic monitor_loop();
        bit          prev_nread  = 1'b1;
        bit          prev_nwrite = 1'b1;
        logic [15:0] prev_addr   = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_nread = 1'b1; prev_nwrite = 1'b1; low_cnt = 0;
            end else begin
                checks++;
                if (!nRead && !nWrite) begin
                    failures++;
                    $display("FAIL strobes_overlap nRead=%b nWrite=%b required not both 0", nRead, nWrite);
                end
                checks++;
                if (nWrite && ExeDataOut !== '0) begin
                    failures++;
                    $display("FAIL idle_write_data got=%h required 0", ExeDataOut);
                end
                if (!nRead) begin
                    if (prev_nread) begin
                        check_event(1'b0, Address, '0);
                    end else begin
                        checks++;
                        if (Address !== prev_addr) begin
                            failures++;
                            $display("FAIL read_addr_hold got=%h required %h", Address, prev_addr);
                        end
                    end
                end
                if (!nWrite) begin
                    checks++;
                    if (!prev_nwrite) begin
                        failures++;
                        $display("FAIL write_pulse_len got=2+ cycles required 1");
                    end
                    check_event(1'b1, Address, ExeDataOut);
                    if (Address[15:8] == 8'h00) begin
                        mem[Address[7:0]] = ExeDataOut;
                    end else if (Address[15:8] == 8'h20) begin
                        case (Address[3:0])
                            4'h0: malu_s1 = ExeDataOut;
                            4'h1: malu_s2 = ExeDataOut;
                            4'h3: begin
                                malu_res = alu_fn(Address & 16'hFFF0, malu_s1, malu_s2);
                                malu_s1  = '0;
                                malu_s2  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                low_cnt     = nRead ? 0 : low_cnt + 1;
                prev_nread  = nRead;
                prev_nwrite = nWrite;
                prev_addr   = Address;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic init_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'hFF00_0000;
            mem[i]  = rand_word();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_nRead"},   DATA_W'(nRead),      DATA_W'(1));
        chk({tag, "_nWrite"},  DATA_W'(nWrite),     DATA_W'(1));
        chk({tag, "_Address"}, DATA_W'(Address),    '0);
        chk({tag, "_ExeData"}, ExeDataOut,          '0);
        chk({tag, "_PcOut"},   DATA_W'(PcOut),      '0);
        chk({tag, "_Halted"},  DATA_W'(Halted),     '0);
        chk({tag, "_Error"},   DATA_W'(Error),      '0);
    endtask

    task automatic run_until_halt(input string tag, input int budget, input bit rand_run);
        int n = 0;
        while (!Halted && n < budget) begin
            @(negedge Clk);
            n++;
            if (rand_run) Run = ($urandom_range(0, 9) < 7);
        end
        checks++;
        if (!Halted) begin
            failures++;
            $display("FAIL %s_halt_timeout got Halted=0 after %0d cycles required 1", tag, budget);
        end
        Run = 1'b1;
        // Quiet period: any further strobe is an unexpected bus event
        repeat (30) @(negedge Clk);
        chk({tag, "_events_left"}, DATA_W'(expq.size()), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] stop_pc;
        bit         stop_err;
        int         n;
        logic [7:0] ops [9];
        logic [7:0] d;

        ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12};
        malu_s1 = '0; malu_s2 = '0; malu_res = '0; low_cnt = 0;

        fork
            monitor_loop();
        join_none

        // ---- Program 1: directed int add, matrix add, scaleimm, illegal ----
        init_mems();
        mem[1] = 256'd7;
        mem[2] = 256'd9;
        imem[0] = 32'h1005_0102;
        imem[1] = 32'h0108_0304;
        imem[2] = 32'h0507_032A;
        imem[3] = 32'h1300_0000;
        Reset = 1'b1; Run = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset1");
        build_expect(stop_pc, stop_err);
        Reset = 1'b0; Run = 1'b1;
        run_until_halt("prog1", 2000, 1'b0);
        chk("prog1_Error",  DATA_W'(Error),  DATA_W'(1));
        chk("prog1_Halted", DATA_W'(Halted), DATA_W'(1));
        chk("prog1_PcOut",  DATA_W'(PcOut),  DATA_W'(3));
        chk("prog1_mem5",   mem[5],          256'd16);

        // ---- Program 2: int sub wrap, then random legal ops, then STOP ----
        Reset = 1'b1; Run = 1'b0;
        init_mems();
        mem[8'h0A] = '0;
        mem[8'h0B] = 256'd1;
        imem[0] = 32'h1106_0A0B;
        n = $urandom_range(12, 20);
        for (int i = 1; i <= n; i++) begin
            d = 8'($urandom_range(0, 255));
            if (d == 8'h06) d = 8'h07;
            imem[i] = {ops[$urandom_range(0, 8)], d, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        end
        repeat (2) @(negedge Clk);
        build_expect(stop_pc, stop_err);
        Reset = 1'b0; Run = 1'b1;
        run_until_halt("prog2", 20000, 1'b1);
        chk("prog2_Error",  DATA_W'(Error),  '0);
        chk("prog2_Halted", DATA_W'(Halted), DATA_W'(1));
        chk("prog2_PcOut",  DATA_W'(PcOut),  DATA_W'(stop_pc));
        chk("prog2_mem6",   mem[6],          {DATA_W{1'b1}});

        // ---- Program 3: reset asserted while waiting on the matrix ALU ----
        Reset = 1'b1; Run = 1'b0;
        init_mems();
        imem[0] = 32'h1020_2122;
        imem[1] = 32'h0230_2425;
        repeat (2) @(negedge Clk);
        build_expect(stop_pc, stop_err);
        Reset = 1'b0; Run = 1'b1;
        n = 0;
        while (!(!nWrite && Address == 16'h2023) && n < 500) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL prog3_go_timeout got no go write to 2023 required one");
        end
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 check_reset_vals("reset_mid");
        @(negedge Clk);
        build_expect(stop_pc, stop_err);
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b1;
        run_until_halt("prog3", 2000, 1'b0);
        chk("prog3_Error",  DATA_W'(Error),  '0);
        chk("prog3_PcOut",  DATA_W'(PcOut),  DATA_W'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Parametrised fetch/decode/execute engine; next generation of the matrix-processor execution unit.
- Fetches 32-bit instructions (op_dest_src1_src2) from instruction memory and reads operands from main memory over the shared nRead/nWrite/Address bus.
- Dispatches matrix ops to the matrix ALU by memory-mapped writes and executes integer ops internally.
- Adds configurable bus/ALU latency, a Run handshake, sticky halt and illegal-opcode error reporting.

Parameters:
- DATA_W, 256: width of all data buses.
- ADDR_W, 16: bus address width.
- PC_W, 8: program counter width.
- INSTR_BASE, 16'h8000: instruction memory base.
- MEM_BASE, 16'h0000: main memory base.
- MALU_BASE, 16'h2000: matrix ALU base.
- RD_LAT, 2: cycles from nRead low to data sampled (>=1).
- ALU_LAT, 1: idle cycles between ALU go-write and result read (>=0).

Ports:
- Clk, in, 1: clock, all state on rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Run, in, 1: permits fetch of a new instruction.
- InstructDataIn, in, DATA_W: instruction memory read data; bits [31:0] used.
- MemDataIn, in, DATA_W: main memory read data.
- MatrixDataIn, in, DATA_W: matrix ALU read data.
- ExeDataOut, out, DATA_W: bus write data.
- Address, out, ADDR_W: bus address.
- nRead, out, 1: active-low read strobe.
- nWrite, out, 1: active-low write strobe.
- PcOut, out, PC_W: current PC.
- Halted, out, 1: STOP executed or error; sticky.
- Error, out, 1: illegal opcode fetched; sticky.

Behaviour:
- One clock (Clk); reset is asynchronous and active-high (Reset); all outputs return to reset values immediately on assertion, including mid-instruction.
- Reset values: nRead=1, nWrite=1, Address=0, ExeDataOut=0, PcOut=0, Halted=0, Error=0; state IDLE.
- Bus read: drive Address, nRead=0; hold both RD_LAT cycles; sample data on the RD_LAT-th rising edge; then nRead=1 for at least one cycle.
- Bus write: Address, ExeDataOut and nWrite=0 valid for exactly one cycle; then nWrite=1.
- nRead and nWrite are never low together. ExeDataOut is 0 whenever nWrite=1, never X.
- Operand/dest address = MEM_BASE + zero-extended 8-bit field. Instruction address = INSTR_BASE + PcOut.
- FSM states: IDLE, FETCH, DECODE, RD_SRC1, RD_SRC2, ALU_WR1, ALU_WR2, ALU_GO, ALU_WAIT, ALU_RD, INT_EXEC, WR_DEST, RETIRE, HALT.
  - IDLE -> FETCH when Run=1.
  - FETCH -> DECODE (one cycle).
  - DECODE branches on opcode.
  - RETIRE: PcOut += 1 modulo 2^PC_W (0xFF wraps to 0); -> FETCH if Run=1, else IDLE.
  - Run dropping mid-instruction has no effect until RETIRE.
- Matrix ops 0x00 MUL, 0x01 ADD, 0x02 SUB, 0x03 TRANSPOSE, 0x04 SCALE, 0x05 SCALEIMM:
  - Sub-base = MALU_BASE | (op[3:0] << 4). Offsets: +0 src1, +1 src2, +3 go (write, data 0), +2 result (read).
  - Sequence: RD_SRC1, RD_SRC2, ALU_WR1, ALU_WR2, ALU_GO, ALU_WAIT (ALU_LAT cycles), ALU_RD, WR_DEST, RETIRE.
  - TRANSPOSE skips RD_SRC2 and ALU_WR2.
  - SCALEIMM skips RD_SRC2 and writes the src2 field zero-extended to DATA_W at offset +1.
- Integer ops:
  - 0x10 ADD: src1+src2, modulo 2^DATA_W.
  - 0x11 SUB: src1-src2, two's complement wrap.
  - 0x12 MUL: src1[DATA_W/2-1:0]*src2[DATA_W/2-1:0], full DATA_W product.
  - Sequence: RD_SRC1, RD_SRC2, INT_EXEC, WR_DEST, RETIRE.
- STOP 0xFF: HALT, Halted=1; bus idle; PcOut holds the STOP address; exit only by Reset.
- Any other opcode, including 0x13: Error=1, Halted=1, HALT; no bus write; PcOut holds the faulting PC.
- dest == src allowed; operands are captured before the write.

Decomposition:
- Shared package exec_pkg: opcode enum (8-bit), state enum, ALU offset constants (SRC1=0, SRC2=1, RES=2, GO=3).
- One sub-module, exec_int_alu: combinational add/sub/mul, parametrised by DATA_W, selected by opcode.

Test Plan:
- Reset, Run=1; PC0 = 0x10_05_01_02, mem[1]=7, mem[2]=9 (RD_LAT=2) -> fetch at 0x8000; one-cycle write of 16 to Address 0x0005; PcOut=1.
- Run=1; PC0 = 0x01_08_03_04 (ALU_LAT=1), ALU returns 0xABCD -> writes to 0x2010, 0x2011, 0x2013, read of 0x2012, then 0xABCD written to 0x0008.
- 0x11_06_01_02 with src1=0, src2=1 -> mem[6] = all-ones (2^256-1).
- 0x05_07_03_2A -> Address 0x2051 written with 0x2A; no read of main memory for src2.
- Illegal 0x13_00_00_00 at PC=3 -> Error=1, Halted=1, PcOut=3; no further nRead/nWrite pulses.
- Reset asserted during ALU_WAIT -> all outputs to reset values in the same cycle; after release with Run=1, fetch restarts at 0x8000.
